// File: rtl/temp_adctemp.sv
// Setpoint (deg C) to raw thermistor ADC code, inverse of the adc-to-temp path.
// Ports: clk, reset, start, temp_in[11:0] s -> adc_out[11:0], busy, valid, clamped.
module temp_adctemp #(
  parameter int unsigned res     = 100000,
  parameter int unsigned voltage = 33,
  parameter int unsigned k       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [11:0] temp_in,
  output logic        [11:0] adc_out,
  output logic               busy,
  output logic               valid,
  output logic               clamped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_FETCH,
    S_INTERP,
    S_PREP,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic signed [11:0] T_MIN = -12'sd55;
  localparam logic signed [11:0] T_MAX = 12'sd300;
  localparam logic signed [11:0] T_OFF = 12'sd55;
  localparam logic [5:0]  LAST = 6'd47;
  localparam logic [47:0] NUMK = 48'(1000 * voltage);
  localparam logic [31:0] KMUL = 32'(k);
  localparam logic [31:0] RDIV = 32'(10 * res);

  state_t state;
  state_t state_nx;

  logic signed [11:0] tc;
  logic               ovr;
  logic [6:0]         idx;
  logic [2:0]         frac;
  logic [31:0]        a;
  logic [31:0]        b;
  logic [31:0]        rt;
  logic [31:0]        den;
  logic [31:0]        rem;
  logic [47:0]        quo;
  logic [5:0]         cnt;
  logic [11:0]        adc_r;
  logic               clamped_r;

  logic signed [11:0] t_lim;
  logic               t_ovr;
  logic [8:0]         tval;
  logic [34:0]        prod;
  logic [47:0]        num_c;
  logic [31:0]        den_c;
  logic [32:0]        rem_sh;
  logic [32:0]        trial;
  logic               qbit;
  logic [31:0]        rem_nx;
  logic [47:0]        quo_nx;
  logic [11:0]        adc_nx;

  // 100k NTC, deci-ohms, entry i at -55+5i degC
  function automatic logic [31:0] rom(input logic [6:0] ad);
    logic [31:0] v;
    case (ad)
      7'd0:  v = 32'd107232360;
      7'd1:  v = 32'd74050000;
      7'd2:  v = 32'd51790000;
      7'd3:  v = 32'd36670000;
      7'd4:  v = 32'd26260000;
      7'd5:  v = 32'd19020000;
      7'd6:  v = 32'd13920000;
      7'd7:  v = 32'd10293000;
      7'd8:  v = 32'd7684500;
      7'd9:  v = 32'd5789800;
      7'd10: v = 32'd4401700;
      7'd11: v = 32'd3373700;
      7'd12: v = 32'd2606700;
      7'd13: v = 32'd2029500;
      7'd14: v = 32'd1591800;
      7'd15: v = 32'd1257400;
      7'd16: v = 32'd1000000;
      7'd17: v = 32'd802230;
      7'd18: v = 32'd644580;
      7'd19: v = 32'd522300;
      7'd20: v = 32'd425780;
      7'd21: v = 32'd348800;
      7'd22: v = 32'd287380;
      7'd23: v = 32'd237970;
      7'd24: v = 32'd197990;
      7'd25: v = 32'd165500;
      7'd26: v = 32'd138950;
      7'd27: v = 32'd117210;
      7'd28: v = 32'd99250;
      7'd29: v = 32'd84420;
      7'd30: v = 32'd72070;
      7'd31: v = 32'd61760;
      7'd32: v = 32'd53130;
      7'd33: v = 32'd45840;
      7'd34: v = 32'd39700;
      7'd35: v = 32'd34490;
      7'd36: v = 32'd30070;
      7'd37: v = 32'd26300;
      7'd38: v = 32'd23060;
      7'd39: v = 32'd20280;
      7'd40: v = 32'd17880;
      7'd41: v = 32'd15810;
      7'd42: v = 32'd14020;
      7'd43: v = 32'd12460;
      7'd44: v = 32'd11100;
      7'd45: v = 32'd9917;
      7'd46: v = 32'd8877;
      7'd47: v = 32'd7965;
      7'd48: v = 32'd7161;
      7'd49: v = 32'd6451;
      7'd50: v = 32'd5826;
      7'd51: v = 32'd5269;
      7'd52: v = 32'd4776;
      7'd53: v = 32'd4336;
      7'd54: v = 32'd3945;
      7'd55: v = 32'd3596;
      7'd56: v = 32'd3282;
      7'd57: v = 32'd3002;
      7'd58: v = 32'd2749;
      7'd59: v = 32'd2522;
      7'd60: v = 32'd2317;
      7'd61: v = 32'd2132;
      7'd62: v = 32'd1965;
      7'd63: v = 32'd1813;
      7'd64: v = 32'd1676;
      7'd65: v = 32'd1551;
      7'd66: v = 32'd1437;
      7'd67: v = 32'd1333;
      7'd68: v = 32'd1238;
      7'd69: v = 32'd1152;
      7'd70: v = 32'd1112;
      7'd71: v = 32'd1078;
      7'd72: v = 32'd1000;
      default: v = 32'd1000;
    endcase
    return v;
  endfunction

  always_comb begin
    t_lim = temp_in;
    t_ovr = 1'b0;
    unique case (1'b1)
      (temp_in < T_MIN): begin
        t_lim = T_MIN;
        t_ovr = 1'b1;
      end
      (temp_in > T_MAX): begin
        t_lim = T_MAX;
        t_ovr = 1'b1;
      end
      default: ;
    endcase
  end

  // offset into the table, 0..355
  assign tval  = 9'(tc + T_OFF);
  assign prod  = 35'(a - b) * 35'(frac);
  assign num_c = {16'd0, rt} * NUMK;
  assign den_c = KMUL * (RDIV + rt);

  // restoring divider step: remainder stays below den
  assign rem_sh = {rem, quo[47]};
  assign trial  = rem_sh - {1'b0, den};
  assign qbit   = ~trial[32];
  assign rem_nx = qbit ? trial[31:0] : rem_sh[31:0];
  assign quo_nx = {quo[46:0], qbit};
  assign adc_nx = (|quo_nx[47:12]) ? 12'hFFF : quo_nx[11:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_IDX;
      S_IDX:    state_nx = S_FETCH;
      S_FETCH:  state_nx = S_INTERP;
      S_INTERP: state_nx = S_PREP;
      S_PREP:   state_nx = S_DIV;
      S_DIV:    if (cnt == LAST) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    valid   = (state == S_DONE);
    adc_out = adc_r;
    clamped = clamped_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc        <= '0;
      ovr       <= 1'b0;
      idx       <= '0;
      frac      <= '0;
      a         <= '0;
      b         <= '0;
      rt        <= '0;
      den       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      adc_r     <= '0;
      clamped_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            tc  <= t_lim;
            ovr <= t_ovr;
          end
        end
        S_IDX: begin
          idx  <= 7'(tval / 9'd5);
          frac <= 3'(tval % 9'd5);
        end
        S_FETCH: begin
          a <= rom(idx);
          b <= rom(idx + 7'd1);
        end
        S_INTERP: begin
          rt <= a - 32'(prod / 35'd5);
        end
        S_PREP: begin
          quo <= num_c;
          rem <= '0;
          den <= den_c;
          cnt <= '0;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
          // final bit lands here so adc_out is ready in DONE
          if (cnt == LAST) begin
            adc_r     <= adc_nx;
            clamped_r <= ovr;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_adctemp.sv
// Bench for temp_adctemp: vector table, corner sequences, random vs model.
// Drives start/temp_in, observes adc_out/busy/valid/clamped.
module tb_temp_adctemp;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [11:0] temp_in = '0;
  logic        [11:0] adc_out;
  logic               busy;
  logic               valid;
  logic               clamped;

  int n_chk = 0;
  int n_fail = 0;

  longint tbl [73] = '{
    107232360, 74050000, 51790000, 36670000, 26260000,
    19020000, 13920000, 10293000, 7684500, 5789800,
    4401700, 3373700, 2606700, 2029500, 1591800,
    1257400, 1000000, 802230, 644580, 522300,
    425780, 348800, 287380, 237970, 197990,
    165500, 138950, 117210, 99250, 84420,
    72070, 61760, 53130, 45840, 39700,
    34490, 30070, 26300, 23060, 20280,
    17880, 15810, 14020, 12460, 11100,
    9917, 8877, 7965, 7161, 6451,
    5826, 5269, 4776, 4336, 3945,
    3596, 3282, 3002, 2749, 2522,
    2317, 2132, 1965, 1813, 1676,
    1551, 1437, 1333, 1238, 1152,
    1112, 1078, 1000
  };

  typedef struct {
    int t;
    int adc;
    bit clp;
  } vec_t;

  vec_t vecs [11];

  temp_adctemp #(
    .res(100000),
    .voltage(33),
    .k(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .temp_in(temp_in),
    .adc_out(adc_out),
    .busy(busy),
    .valid(valid),
    .clamped(clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int t_in, output int adc, output bit clp);
    int t;
    int off;
    int i;
    int f;
    longint rt;
    longint q;
    t = t_in;
    clp = 1'b0;
    if (t < -55) begin
      t = -55;
      clp = 1'b1;
    end
    if (t > 300) begin
      t = 300;
      clp = 1'b1;
    end
    off = t + 55;
    i = off / 5;
    f = off % 5;
    rt = tbl[i] - ((tbl[i] - tbl[i+1]) * f) / 5;
    q = (rt * 1000 * 33) / (10 * (10 * 100000 + rt));
    adc = (q > 4095) ? 4095 : int'(q);
  endfunction

  task automatic run_conv(input int t, output int adc, output bit clp, output int lat);
    int bad;
    @(negedge clk);
    start = 1'b1;
    temp_in = 12'(t);
    @(posedge clk);
    #1;
    start = 1'b0;
    temp_in = 12'($urandom);
    chk("busy_after_start", busy, 1);
    lat = -1;
    adc = -1;
    clp = 1'b0;
    bad = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        adc = int'(adc_out);
        clp = clamped;
        break;
      end
      if (!busy) bad++;
    end
    chk("busy_window", bad, 0);
    chk("latency", lat, 52);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    int adc;
    bit clp;
    int lat;
    int ea;
    bit ec;
    int nv;
    int last_t;
    int t;
    int seen [$];

    vecs[0]  = '{25, 1650, 1'b0};
    vecs[1]  = '{27, 1582, 1'b0};
    vecs[2]  = '{26, 1616, 1'b0};
    vecs[3]  = '{30, 1468, 1'b0};
    vecs[4]  = '{300, 3, 1'b0};
    vecs[5]  = '{-55, 3269, 1'b0};
    vecs[6]  = '{400, 3, 1'b1};
    vecs[7]  = '{-100, 3269, 1'b1};
    vecs[8]  = '{25, 1650, 1'b0};
    vecs[9]  = '{2047, 3, 1'b1};
    vecs[10] = '{-2048, 3269, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_adc", adc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_clamped", clamped, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_conv(vecs[i].t, adc, clp, lat);
      chk($sformatf("vec%0d_adc", i), adc, vecs[i].adc);
      chk($sformatf("vec%0d_clamped", i), clp, vecs[i].clp);
      chk($sformatf("vec%0d_hold", i), adc_out, vecs[i].adc);
    end

    // second start 10 cycles in must be ignored
    @(negedge clk);
    start = 1'b1;
    temp_in = 12'sd25;
    nv = 0;
    adc = -1;
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk);
      #1;
      start = (n == 10);
      temp_in = (n == 10) ? 12'sd300 : 12'sd25;
      if (valid) begin
        nv++;
        adc = int'(adc_out);
      end
    end
    start = 1'b0;
    chk("ignore_nvalid", nv, 1);
    chk("ignore_adc", adc, 1650);
    chk("ignore_idle", busy, 0);

    // reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    temp_in = 12'sd27;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_adc", adc_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (valid || busy) nv++;
    end
    chk("abort_quiet", nv, 0);
    run_conv(27, adc, clp, lat);
    chk("after_abort_adc", adc, 1582);

    // reset and start together: start dropped
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    temp_in = 12'sd25;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_busy", busy, 0);

    // start held high: back-to-back every 54 cycles
    @(negedge clk);
    start = 1'b1;
    temp_in = 12'sd25;
    nv = 0;
    for (int n = 1; n <= 240; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        seen.push_back(n);
        if (adc_out != 12'd1650) nv++;
      end
    end
    start = 1'b0;
    chk("held_count", seen.size(), 4);
    chk("held_adc", nv, 0);
    for (int i = 1; i < seen.size(); i++)
      chk("held_period", seen[i] - seen[i-1], 54);
    nv = 0;
    for (int n = 0; n < 100 && busy; n++) begin
      @(posedge clk);
      #1;
      nv = n;
    end
    chk("held_drain", busy, 0);

    // random setpoints against the model
    last_t = 0;
    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 7) t = int'($signed(12'($urandom)));
      else t = int'($urandom_range(0, 520)) - 110;
      model(t, ea, ec);
      run_conv(t, adc, clp, lat);
      chk($sformatf("rand_adc t=%0d", t), adc, ea);
      chk($sformatf("rand_clamped t=%0d", t), clp, ec);
      last_t = t;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
